// File: rtl/div_unit_if.sv
// div_unit_if -- request/result bundle for the iterative RV32M divide unit.
//
// Signals (names seen from the divider's side):
//   i_valid     requester -> divider  request strobe
//   o_ready     divider -> requester  divider idle, request can be taken
//   i_op_a      requester -> divider  dividend (32 bits)
//   i_op_b      requester -> divider  divisor (32 bits)
//   i_div_op    requester -> divider  00 DIV, 01 DIVU, 10 REM, 11 REMU
//   o_valid     divider -> requester  one-cycle result strobe
//   o_div_data  divider -> requester  result, held after the strobe
//
// Modports: master = requester (execute-stage control), slave = divider.
interface div_unit_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic [1:0]  i_div_op;
  logic        o_valid;
  logic [31:0] o_div_data;

  modport master (
    output i_valid, i_op_a, i_op_b, i_div_op,
    input  o_ready, o_valid, o_div_data
  );

  modport slave (
    input  i_valid, i_op_a, i_op_b, i_div_op,
    output o_ready, o_valid, o_div_data
  );
endinterface

// File: rtl/div_unit.sv
// div_unit -- iterative 32-bit divider for DIV, DIVU, REM and REMU.
//
// A radix-2 restoring divider working on operand magnitudes; the sign is
// applied on the way out. Divide-by-zero and the signed overflow case skip
// the iteration and produce their fixed results one cycle after acceptance.
//
// Ports:
//   i_clk    clock, all state changes on the rising edge
//   i_reset  synchronous active-high reset; aborts any operation in flight
//   bus      div_unit_if.slave: valid/ready request, op/operands, result
//            strobe o_valid and result o_div_data
//
// Timing: a request accepted in cycle 0 returns o_valid in cycle 33
// (cycle 1 for the special cases); o_ready stays low until the cycle
// after o_valid.
module div_unit (
  input  logic       i_clk,
  input  logic       i_reset,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;       // partial remainder
  logic [31:0] quo_q, quo_d;       // dividend bits shifting out, quotient in
  logic [31:0] dvs_q, dvs_d;       // divisor magnitude
  logic        rem_op_q, rem_op_d; // result select: 1 = remainder
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] data_q, data_d;

  // Request-side decode
  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        div_zero;
  logic        sgn_ovf;

  assign signed_op = ~bus.i_div_op[0];
  assign a_neg     = signed_op & bus.i_op_a[31];
  assign b_neg     = signed_op & bus.i_op_b[31];
  // -(2^31) stays 32'h8000_0000, which is still the right unsigned magnitude
  assign a_abs     = a_neg ? (~bus.i_op_a + 32'd1) : bus.i_op_a;
  assign b_abs     = b_neg ? (~bus.i_op_b + 32'd1) : bus.i_op_b;
  assign div_zero  = (bus.i_op_b == 32'd0);
  assign sgn_ovf   = signed_op && (bus.i_op_a == 32'h8000_0000) &&
                     (bus.i_op_b == 32'hFFFF_FFFF);

  // One restoring step. The shifted remainder needs 33 bits; bit 32 of the
  // trial difference is the borrow, i.e. "divisor did not fit".
  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic        trial_ok;
  logic [31:0] step_rem;
  logic [31:0] step_quo;
  logic [31:0] fin_rem;
  logic [31:0] fin_quo;

  assign rem_shift = {rem_q, quo_q[31]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign trial_ok  = ~trial[32];
  assign step_rem  = trial_ok ? trial[31:0] : rem_shift[31:0];
  assign step_quo  = {quo_q[30:0], trial_ok};
  assign fin_quo   = neg_quo_q ? (~step_quo + 32'd1) : step_quo;
  assign fin_rem   = neg_rem_q ? (~step_rem + 32'd1) : step_rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_op_d  = rem_op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    data_d    = data_q;

    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          rem_op_d  = bus.i_div_op[1];
          neg_quo_d = signed_op & (bus.i_op_a[31] ^ bus.i_op_b[31]);
          neg_rem_d = a_neg;
          if (div_zero) begin
            data_d  = bus.i_div_op[1] ? bus.i_op_a : 32'hFFFF_FFFF;
            state_d = DONE;
          end else if (sgn_ovf) begin
            data_d  = bus.i_div_op[1] ? 32'd0 : 32'h8000_0000;
            state_d = DONE;
          end else begin
            rem_d   = 32'd0;
            quo_d   = a_abs;
            dvs_d   = b_abs;
            cnt_d   = 5'd0;
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 5'd1;
        // The last step's result goes straight to the output register so
        // o_div_data only moves on the way into DONE.
        if (cnt_q == 5'd31) begin
          data_d  = rem_op_q ? fin_rem : fin_quo;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      rem_op_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      data_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rem_op_q  <= rem_op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      data_q    <= data_d;
    end
  end

  assign bus.o_ready    = (state_q == IDLE);
  assign bus.o_valid    = (state_q == DONE);
  assign bus.o_div_data = data_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases, special cases,
// randomized operations against a plain-arithmetic reference model,
// back-to-back handshaking and reset in the middle of an operation.
module tb_div_unit;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  div_unit_if bus ();

  div_unit dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish, got hang required finish");
    $fatal(1, "timeout");
  end

  // Reference model: RISC-V M semantics with 64-bit arithmetic so the
  // signed overflow case cannot trap.
  function automatic logic [31:0] model_div(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int model_lat(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic gen_req(output logic [1:0] op, output logic [31:0] a,
                         output logic [31:0] b);
    int sel;
    sel = int'($urandom_range(0, 7));
    op  = 2'($urandom_range(0, 3));
    a   = $urandom;
    b   = $urandom;
    case (sel)
      0: b = 32'd0;
      1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50);
               if ($urandom_range(0, 1) == 1) a = ~a + 32'd1;
               if ($urandom_range(0, 1) == 1) b = ~b + 32'd1; end
      3: b = $urandom_range(1, 15);
      4: b = 32'hFFFF_FFFF - $urandom_range(0, 9);
      default: ;
    endcase
  endtask

  // Issue one request and wait for its result. Operands are scrambled
  // right after acceptance so the latched copies are what gets used.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output int lat, output logic [31:0] held,
                        output bit hs_bad, output bit after_ok);
    int guard;
    res = '0; lat = -1; held = '0; hs_bad = 1'b0; after_ok = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!bus.o_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.i_valid  = 1'b1;
    bus.i_op_a   = a;
    bus.i_op_b   = b;
    bus.i_div_op = op;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid  = 1'b0;
    bus.i_op_a   = $urandom;
    bus.i_op_b   = $urandom;
    bus.i_div_op = 2'($urandom_range(0, 3));
    for (int k = 1; k <= 100; k++) begin
      if (bus.o_ready) hs_bad = 1'b1;
      if (bus.o_valid) begin
        lat = k;
        res = bus.o_div_data;
        break;
      end
      @(negedge clk);
    end
    if (lat > 0) begin
      @(negedge clk);
      held     = bus.o_div_data;
      after_ok = bus.o_ready && !bus.o_valid;
    end
  endtask

  task automatic test_reset();
    int vcount;
    int rdy_low;
    rst          = 1'b1;
    bus.i_valid  = 1'b1;           // request presented during reset
    bus.i_op_a   = 32'd77;
    bus.i_op_b   = 32'd0;
    bus.i_div_op = 2'b01;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b required 1", bus.o_ready);
    end
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b required 0", bus.o_valid);
    end
    checks++;
    if (bus.o_div_data !== 32'd0) begin
      errors++; $display("FAIL reset_data got %h required 0", bus.o_div_data);
    end
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    vcount = 0; rdy_low = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_valid) vcount++;
      if (!bus.o_ready) rdy_low++;
    end
    checks++;
    if (vcount !== 0 || rdy_low !== 0) begin
      errors++;
      $display("FAIL reset_drop got valids=%0d busy=%0d required 0/0", vcount, rdy_low);
    end
    $display("reset: state checked, request during reset dropped");
  endtask

  logic [1:0]  d_op  [10] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10,
                              2'b00, 2'b11, 2'b00, 2'b10};
  logic [31:0] d_a   [10] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd7, 32'd7, 32'd5, 32'd5,
                              32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b   [10] = '{32'd7, 32'd7, 32'd2, 32'd2,
                              32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp [10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFF, 32'd5,
                              32'h8000_0000, 32'd0};
  int          d_lat [10] = '{33, 33, 33, 33, 33, 33, 1, 1, 1, 1};

  task automatic test_directed();
    logic [31:0] res, held;
    int lat;
    bit hs_bad, after_ok;
    for (int i = 0; i < 10; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], res, lat, held, hs_bad, after_ok);
      $display("directed op=%b a=%h b=%h res=%h lat=%0d", d_op[i], d_a[i], d_b[i], res, lat);
      checks++;
      if (res !== d_exp[i]) begin
        errors++; $display("FAIL directed_data[%0d] got %h required %h", i, res, d_exp[i]);
      end
      checks++;
      if (lat !== d_lat[i]) begin
        errors++; $display("FAIL directed_latency[%0d] got %0d required %0d", i, lat, d_lat[i]);
      end
      checks++;
      if (hs_bad !== 1'b0) begin
        errors++; $display("FAIL directed_ready_low[%0d] got ready high while busy required low", i);
      end
      checks++;
      if (after_ok !== 1'b1 || held !== d_exp[i]) begin
        errors++;
        $display("FAIL directed_after[%0d] got ready_ok=%b held=%h required 1 %h", i, after_ok, held, d_exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, res, held, exp;
    int lat, elat;
    bit hs_bad, after_ok;
    for (int i = 0; i < 40; i++) begin
      gen_req(op, a, b);
      exp  = model_div(op, a, b);
      elat = model_lat(op, a, b);
      run_op(op, a, b, res, lat, held, hs_bad, after_ok);
      $display("random op=%b a=%h b=%h res=%h lat=%0d", op, a, b, res, lat);
      checks++;
      if (res !== exp || lat !== elat) begin
        errors++;
        $display("FAIL random_op[%0d] got %h/%0d required %h/%0d", i, res, lat, exp, elat);
      end
      checks++;
      if (hs_bad !== 1'b0 || after_ok !== 1'b1 || held !== exp) begin
        errors++;
        $display("FAIL random_handshake[%0d] got bad=%b ok=%b held=%h required 0 1 %h", i, hs_bad, after_ok, held, exp);
      end
    end
  endtask

  // i_valid stays high with new operands every cycle; the bench predicts
  // which ones get accepted from o_ready and when each result must appear.
  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    int          due_q[$];
    logic [1:0]  op;
    logic [31:0] a, b, exp_v;
    int          due;
    int          nacc, nres;
    bit          prev_valid;
    nacc = 0; nres = 0; prev_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (bus.o_valid) begin
        checks++;
        if (prev_valid) begin
          errors++; $display("FAIL b2b_double_valid at cycle %0d got 2 cycles required 1", cyc);
        end
        nres++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got result %h required none", bus.o_div_data);
        end else begin
          exp_v = exp_q.pop_front();
          due   = due_q.pop_front();
          $display("b2b result=%h cycle=%0d", bus.o_div_data, cyc);
          if (bus.o_div_data !== exp_v || cyc !== due) begin
            errors++;
            $display("FAIL b2b_result got %h@%0d required %h@%0d", bus.o_div_data, cyc, exp_v, due);
          end
        end
      end
      if (prev_valid) begin
        checks++;
        if (bus.o_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready_return got %b required 1", bus.o_ready);
        end
      end
      prev_valid = bus.o_valid;
      if (nacc < 6) begin
        gen_req(op, a, b);
        if (nacc % 2 == 1) b = 32'd0;   // mix in short special-case ops
        bus.i_valid  = 1'b1;
        bus.i_op_a   = a;
        bus.i_op_b   = b;
        bus.i_div_op = op;
        if (bus.o_ready) begin
          exp_q.push_back(model_div(op, a, b));
          due_q.push_back(cyc + model_lat(op, a, b));
          nacc++;
        end
      end else begin
        bus.i_valid = 1'b0;
      end
      if (nacc == 6 && exp_q.size() == 0) break;
    end
    bus.i_valid = 1'b0;
    checks++;
    if (nres !== 6 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count got %0d results required 6", nres);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res, held;
    int lat, vcount, guard;
    bit hs_bad, after_ok;
    run_op(2'b01, 32'd1000, 32'd3, res, lat, held, hs_bad, after_ok);
    $display("pre-reset op=01 a=000003e8 b=00000003 res=%h lat=%0d", res, lat);
    checks++;
    if (res !== 32'd333) begin
      errors++; $display("FAIL prereset_data got %h required %h", res, 32'd333);
    end
    @(negedge clk);
    guard = 0;
    while (!bus.o_ready && guard < 100) begin @(negedge clk); guard++; end
    bus.i_valid  = 1'b1;
    bus.i_op_a   = 32'h1234_5678;
    bus.i_op_b   = 32'd3;
    bus.i_div_op = 2'b00;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.i_valid = 1'b0;
      if (k == 10) rst = 1'b1;       // edge that would run step 10 resets
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_div_data !== 32'd0) begin
      errors++;
      $display("FAIL midreset_state got ready=%b valid=%b data=%h required 1 0 0",
               bus.o_ready, bus.o_valid, bus.o_div_data);
    end
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_valid) vcount++;
    end
    checks++;
    if (vcount !== 0) begin
      errors++; $display("FAIL midreset_stale got %0d valids required 0", vcount);
    end
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, res, lat, held, hs_bad, after_ok);
    $display("post-reset op=01 a=ffffffff b=00000001 res=%h lat=%0d", res, lat);
    checks++;
    if (res !== 32'hFFFF_FFFF || lat !== 33) begin
      errors++; $display("FAIL postreset_op got %h/%0d required ffffffff/33", res, lat);
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    bus.i_valid  = 1'b0;
    bus.i_op_a   = 32'd0;
    bus.i_op_b   = 32'd0;
    bus.i_div_op = 2'b00;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divide unit for the RV32M divide and remainder ops: DIV, DIVU, REM and REMU.
- Sits beside the combinational ALU in the execute stage and takes the same i_op_a / i_op_b operand buses.
- Unlike the ALU it is multi-cycle: a valid/ready request handshake in, a one-cycle result strobe out.
- The control path stalls the core while o_ready is low.

Parameters:
- None. Data width is fixed at 32. The op encoding is fixed as given under Behaviour.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge
- i_reset  input  1  synchronous, active-high reset
- i_valid  input  1  request strobe; operands and op are sampled when i_valid & o_ready
- o_ready  output  1  unit idle and able to accept a request
- i_op_a  input  32  dividend
- i_op_b  input  32  divisor
- i_div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- o_valid  output  1  result strobe; high for exactly one cycle
- o_div_data  output  32  result; valid while o_valid is high, holds its value afterwards

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - state becomes IDLE; o_ready=1, o_valid=0, o_div_data=0, iteration counter=0.
  - Reset asserted mid-operation aborts the operation; no o_valid is produced for it.
  - A request presented in the same cycle as reset is dropped.
- States: IDLE, BUSY, DONE.
- IDLE:
  - o_ready=1, o_valid=0.
  - On i_valid=1, latch the op and operands.
  - Special case divisor==0: go to DONE with the result preloaded.
    - DIV/DIVU quotient = 32'hFFFF_FFFF.
    - REM/REMU remainder = i_op_a.
  - Special case signed overflow (DIV/REM with i_op_a=32'h8000_0000 and i_op_b=32'hFFFF_FFFF): go to DONE.
    - quotient = 32'h8000_0000; remainder = 0.
  - Otherwise go to BUSY with the counter at 0.
  - For signed ops, latch |a| and |b| and record the quotient sign (sign_a ^ sign_b) and the remainder sign (sign_a).
- BUSY:
  - o_ready=0. One radix-2 restoring step per cycle.
  - Shift {rem, quo} left by 1, bringing in the next dividend bit.
  - Trial-subtract the divisor from the 33-bit partial remainder.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore.
  - After 32 steps (counter 31 → wrap), go to DONE.
- DONE:
  - o_valid=1 for one cycle; o_div_data = selected result, sign-corrected.
  - Quotient is negated if the quotient sign is set (DIV only).
  - Remainder is negated if the remainder sign is set (REM only).
  - Unsigned ops are never corrected.
  - o_ready=0; next state is IDLE.
- Latency, counted from the accepting edge to the edge that raises o_valid:
  - normal op: 33 cycles, so o_valid is high in the 33rd cycle after acceptance.
  - special case: 1 cycle.
- Throughput: one request per latency+1 cycles. A request cannot be accepted in the DONE cycle.
- i_valid while o_ready=0 is ignored; the requester must hold it until accepted.
- Operand and op inputs may change freely after acceptance; the latched copies are used.
- Results follow the RISC-V M spec exactly, including REM sign = dividend sign and truncation toward zero.
- o_div_data changes only at the DONE transition and at reset.

Test Plan:
- DIVU 100/7: i_op_a=100, i_op_b=7, op=01 → o_valid 33 cycles after accept, o_div_data=14; REMU same operands → 2.
- Signed: DIV -7/2 → 32'hFFFF_FFFD (-3); REM -7/2 → 32'hFFFF_FFFF (-1); DIV 7/-2 → -3; REM 7/-2 → 1.
- Divide by zero: DIV 5/0 → 32'hFFFF_FFFF; REMU 5/0 → 5; both with o_valid 1 cycle after accept and o_ready low in between.
- Overflow: DIV 32'h8000_0000 / 32'hFFFF_FFFF → 32'h8000_0000; REM same → 0; 1-cycle latency.
- Handshake and back-to-back:
  - hold i_valid high continuously with changing operands; only the first is accepted while busy.
  - o_ready returns 1 the cycle after o_valid, and the next request is accepted there.
  - o_valid is never high for two consecutive cycles.
- Reset mid-operation: assert i_reset for 1 cycle at BUSY step 10 → next cycle o_ready=1, o_valid=0, o_div_data=0. No stale o_valid follows; a fresh DIVU 32'hFFFF_FFFF/1 then returns 32'hFFFF_FFFF.
